// File: rtl/alu_pkg.sv
// Shared types for the ALU arbiter: opcode encoding, FSM state, opcode sanitizer.
// The build macro ALU_ARB_RR_EN is consumed in alu_arbiter.sv.
package alu_pkg;

  typedef logic [3:0] op_t;

  localparam op_t OP_ADD = 4'd0;
  localparam op_t OP_SUB = 4'd1;
  localparam op_t OP_MUL = 4'd2;
  localparam op_t OP_AND = 4'd3;
  localparam op_t OP_OR  = 4'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Undefined opcodes are issued to the ALU as ADD.
  function automatic op_t op_sanitize(input op_t op);
    return (op > OP_OR) ? OP_ADD : op;
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Bundle of requester, response and ALU-side signals for alu_arbiter.
// slave = the arbiter's view; master = the environment (requesters + ALU).
interface alu_arbiter_if;
  import alu_pkg::*;

  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  op_t         req0_op, req1_op;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;

  logic        alu_valid;
  op_t         alu_op;
  logic [31:0] alu_a, alu_b;
  logic [31:0] alu_result;

  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready, rsp1_ready;
  logic [31:0] rsp_data;

  modport slave (
    input  req0_valid, req1_valid, req0_op, req1_op,
           req0_a, req0_b, req1_a, req1_b,
           alu_result, rsp0_ready, rsp1_ready,
    output req0_ready, req1_ready, alu_valid, alu_op, alu_a, alu_b,
           rsp0_valid, rsp1_valid, rsp_data
  );

  modport master (
    output req0_valid, req1_valid, req0_op, req1_op,
           req0_a, req0_b, req1_a, req1_b,
           alu_result, rsp0_ready, rsp1_ready,
    input  req0_ready, req1_ready, alu_valid, alu_op, alu_a, alu_b,
           rsp0_valid, rsp1_valid, rsp_data
  );

endinterface

// File: rtl/alu_arb_pick.sv
// Combinational two-way grant. prio_i selects which requester wins a tie;
// a lone valid requester always wins.
module alu_arb_pick (
  input  logic [1:0] valid_i,
  input  logic       prio_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o    = 2'b00;
    gnt_o[0] = valid_i[0] & (~valid_i[1] | ~prio_i);
    gnt_o[1] = valid_i[1] & (~valid_i[0] |  prio_i);
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester front end for a shared multi-cycle ALU: IDLE -> EXEC -> RESP,
// one op in flight. Define ALU_ARB_RR_EN for round-robin, else req0 has fixed priority.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned MUL_LAT = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  alu_arbiter_if.slave bus
);

  localparam logic [3:0] MUL_CNT = 4'(MUL_LAT - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        gnt_q, gnt_d;
  logic        alu_valid_q, alu_valid_d;
  op_t         alu_op_q, alu_op_d;
  logic [31:0] alu_a_q, alu_a_d;
  logic [31:0] alu_b_q, alu_b_d;
  logic [1:0]  rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_data_q, rsp_data_d;

  logic [1:0]  req_valid, pick_gnt, req_ready, rsp_ready;
  logic        prio, accept, acc_id;
  op_t         acc_op;

`ifdef ALU_ARB_RR_EN
  // Pointer holds the requester that wins the next tie; it moves off each winner.
  logic ptr_q, ptr_d;
  assign prio = ptr_q;
`else
  assign prio = 1'b0;
`endif

  assign req_valid = {bus.req1_valid, bus.req0_valid};
  assign rsp_ready = {bus.rsp1_ready, bus.rsp0_ready};

  alu_arb_pick u_pick (
    .valid_i (req_valid),
    .prio_i  (prio),
    .gnt_o   (pick_gnt)
  );

  assign req_ready = (rst_n && state_q == ST_IDLE) ? pick_gnt : 2'b00;
  assign accept    = |req_ready;
  assign acc_id    = req_ready[1];
  assign acc_op    = op_sanitize(acc_id ? bus.req1_op : bus.req0_op);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    gnt_d       = gnt_q;
    alu_valid_d = alu_valid_q;
    alu_op_d    = alu_op_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
`ifdef ALU_ARB_RR_EN
    ptr_d       = ptr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d     = ST_EXEC;
          gnt_d       = acc_id;
          alu_valid_d = 1'b1;
          alu_op_d    = acc_op;
          alu_a_d     = acc_id ? bus.req1_a : bus.req0_a;
          alu_b_d     = acc_id ? bus.req1_b : bus.req0_b;
          cnt_d       = (acc_op == OP_MUL) ? MUL_CNT : 4'd0;
`ifdef ALU_ARB_RR_EN
          ptr_d       = ~acc_id;
`endif
        end
      end
      ST_EXEC: begin
        if (cnt_q == 4'd0) begin
          state_d     = ST_RESP;
          alu_valid_d = 1'b0;
          rsp_data_d  = bus.alu_result;
          rsp_valid_d = gnt_q ? 2'b10 : 2'b01;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (|(rsp_valid_q & rsp_ready)) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 2'b00;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      gnt_q       <= 1'b0;
      alu_valid_q <= 1'b0;
      alu_op_q    <= OP_ADD;
      alu_a_q     <= 32'd0;
      alu_b_q     <= 32'd0;
      rsp_valid_q <= 2'b00;
      rsp_data_q  <= 32'd0;
`ifdef ALU_ARB_RR_EN
      ptr_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      gnt_q       <= gnt_d;
      alu_valid_q <= alu_valid_d;
      alu_op_q    <= alu_op_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
`ifdef ALU_ARB_RR_EN
      ptr_q       <= ptr_d;
`endif
    end
  end

  assign bus.req0_ready = req_ready[0];
  assign bus.req1_ready = req_ready[1];
  assign bus.alu_valid  = alu_valid_q;
  assign bus.alu_op     = alu_op_q;
  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.rsp0_valid = rsp_valid_q[0];
  assign bus.rsp1_valid = rsp_valid_q[1];
  assign bus.rsp_data   = rsp_data_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter (MUL_LAT=3); arbitration expectations follow ALU_ARB_RR_EN.
module tb_alu_arbiter;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  alu_arbiter_if ifc ();

  alu_arbiter #(.MUL_LAT(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.slave)
  );

  // Behavioural ALU feeding alu_result.
  always_comb begin
    case (ifc.alu_op)
      OP_ADD:  ifc.alu_result = ifc.alu_a + ifc.alu_b;
      OP_SUB:  ifc.alu_result = ifc.alu_a - ifc.alu_b;
      OP_MUL:  ifc.alu_result = ifc.alu_a * ifc.alu_b;
      OP_AND:  ifc.alu_result = ifc.alu_a & ifc.alu_b;
      OP_OR:   ifc.alu_result = ifc.alu_a | ifc.alu_b;
      default: ifc.alu_result = 32'hdead_beef;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int av, rt, ng;
    logic [31:0] rdat;
    int gcyc [4];
    int gid  [4];
    int exp_g[4];

    ifc.req0_valid = 1'b1; ifc.req1_valid = 1'b1;
    ifc.req0_op = OP_ADD; ifc.req1_op = OP_ADD;
    ifc.req0_a = 32'd0; ifc.req0_b = 32'd0; ifc.req1_a = 32'd0; ifc.req1_b = 32'd0;
    ifc.rsp0_ready = 1'b0; ifc.rsp1_ready = 1'b0;

    // Reset state, with both requesters asserting valid.
    tick(); tick(); #1;
    chk("rst_req0_ready", ifc.req0_ready, 0);
    chk("rst_req1_ready", ifc.req1_ready, 0);
    chk("rst_alu_valid",  ifc.alu_valid, 0);
    chk("rst_alu_op",     ifc.alu_op, 0);
    chk("rst_alu_a",      ifc.alu_a, 0);
    chk("rst_rsp0_valid", ifc.rsp0_valid, 0);
    chk("rst_rsp1_valid", ifc.rsp1_valid, 0);
    chk("rst_rsp_data",   ifc.rsp_data, 0);
    ifc.req0_valid = 1'b0; ifc.req1_valid = 1'b0;
    tick();
    rst_n = 1'b1;

    // req0 ADD 5+7: rsp at T+2.
    ifc.req0_valid = 1'b1; ifc.req0_op = OP_ADD; ifc.req0_a = 32'd5; ifc.req0_b = 32'd7;
    ifc.rsp0_ready = 1'b1;
    #1;
    chk("add_req0_ready", ifc.req0_ready, 1);
    chk("add_req1_ready", ifc.req1_ready, 0);
    tick();
    ifc.req0_valid = 1'b0;
    #1;
    chk("add_exec_valid", ifc.alu_valid, 1);
    chk("add_exec_op",    ifc.alu_op, OP_ADD);
    chk("add_exec_a",     ifc.alu_a, 5);
    chk("add_exec_b",     ifc.alu_b, 7);
    chk("add_t1_rsp0",    ifc.rsp0_valid, 0);
    tick();
    chk("add_t2_rsp0",    ifc.rsp0_valid, 1);
    chk("add_t2_data",    ifc.rsp_data, 12);
    chk("add_t2_rsp1",    ifc.rsp1_valid, 0);
    chk("add_t2_aluv",    ifc.alu_valid, 0);
    tick();
    chk("add_t3_rsp0",    ifc.rsp0_valid, 0);
    ifc.rsp0_ready = 1'b0;

    // req1 MUL 6*7: alu_valid for 3 cycles, rsp at T+4.
    ifc.req1_valid = 1'b1; ifc.req1_op = OP_MUL; ifc.req1_a = 32'd6; ifc.req1_b = 32'd7;
    ifc.rsp1_ready = 1'b1;
    #1;
    chk("mul_req1_ready", ifc.req1_ready, 1);
    av = 0; rt = -1; rdat = 32'd0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i == 1) ifc.req1_valid = 1'b0;
      if (ifc.alu_valid) av++;
      if (ifc.rsp1_valid && rt < 0) begin
        rt = i;
        rdat = ifc.rsp_data;
      end
    end
    chk("mul_alu_cycles", av, 3);
    chk("mul_rsp_lat",    rt, 4);
    chk("mul_rsp_data",   rdat, 42);
    ifc.rsp1_ready = 1'b0;

    // Undefined opcode 9 runs as ADD.
    ifc.req0_valid = 1'b1; ifc.req0_op = 4'd9; ifc.req0_a = 32'd3; ifc.req0_b = 32'd4;
    tick();
    ifc.req0_valid = 1'b0;
    chk("op9_alu_op", ifc.alu_op, OP_ADD);
    tick();
    chk("op9_rsp0",   ifc.rsp0_valid, 1);
    chk("op9_data",   ifc.rsp_data, 7);
    ifc.rsp0_ready = 1'b1;
    tick();
    ifc.rsp0_ready = 1'b0;

    // Response back-pressure: req1 held off until req0's response is taken.
    ifc.req0_valid = 1'b1; ifc.req0_op = OP_SUB; ifc.req0_a = 32'd20; ifc.req0_b = 32'd8;
    #1;
    chk("bp_req0_ready", ifc.req0_ready, 1);
    tick();
    ifc.req0_valid = 1'b0;
    ifc.req1_valid = 1'b1; ifc.req1_op = OP_ADD; ifc.req1_a = 32'd1; ifc.req1_b = 32'd1;
    ifc.rsp1_ready = 1'b1;
    #1;
    chk("bp_exec_req1_ready", ifc.req1_ready, 0);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp_rsp0_valid", ifc.rsp0_valid, 1);
      chk("bp_rsp_data",   ifc.rsp_data, 12);
      chk("bp_req1_ready", ifc.req1_ready, 0);
      tick();
    end
    ifc.rsp0_ready = 1'b1;
    #1;
    chk("bp_hs_req1_ready", ifc.req1_ready, 0);
    tick();
    ifc.rsp0_ready = 1'b0;
    #1;
    chk("bp_idle_rsp0",       ifc.rsp0_valid, 0);
    chk("bp_idle_req1_ready", ifc.req1_ready, 1);
    tick();
    ifc.req1_valid = 1'b0;
    chk("bp_req1_exec_a", ifc.alu_a, 1);
    tick();
    chk("bp_req1_rsp1",   ifc.rsp1_valid, 1);
    chk("bp_req1_data",   ifc.rsp_data, 2);
    tick();
    ifc.rsp1_ready = 1'b0;

    // Both requesters valid every cycle, fresh from reset.
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
`ifdef ALU_ARB_RR_EN
    exp_g = '{0, 1, 0, 1};
`else
    exp_g = '{0, 0, 0, 0};
`endif
    gid = '{-1, -1, -1, -1};
    gcyc = '{0, 0, 0, 0};
    ifc.req0_valid = 1'b1; ifc.req0_op = OP_ADD; ifc.req0_a = 32'd1; ifc.req0_b = 32'd2;
    ifc.req1_valid = 1'b1; ifc.req1_op = OP_ADD; ifc.req1_a = 32'd3; ifc.req1_b = 32'd4;
    ifc.rsp0_ready = 1'b1; ifc.rsp1_ready = 1'b1;
    ng = 0;
    for (int c = 0; c < 40 && ng < 4; c++) begin
      #1;
      if (ifc.req0_ready || ifc.req1_ready) begin
        chk("arb_one_hot", {ifc.req1_ready, ifc.req0_ready} == 2'b11, 0);
        gid[ng]  = ifc.req1_ready ? 1 : 0;
        gcyc[ng] = c;
        ng++;
      end
      tick();
    end
    ifc.req0_valid = 1'b0; ifc.req1_valid = 1'b0;
    chk("arb_count", ng, 4);
    for (int i = 0; i < 4; i++) chk("arb_grant", gid[i], exp_g[i]);
    chk("arb_spacing", gcyc[1] - gcyc[0], 3);
    for (int i = 0; i < 4; i++) tick();
    ifc.rsp0_ready = 1'b0; ifc.rsp1_ready = 1'b0;

    // Reset on the 2nd MUL EXEC cycle discards the op.
    ifc.req0_valid = 1'b1; ifc.req0_op = OP_MUL; ifc.req0_a = 32'd6; ifc.req0_b = 32'd7;
    ifc.rsp0_ready = 1'b1;
    #1;
    chk("rstx_req0_ready", ifc.req0_ready, 1);
    tick();
    ifc.req0_valid = 1'b0;
    tick();
    chk("rstx_exec2_valid", ifc.alu_valid, 1);
    rst_n = 1'b0;
    tick();
    chk("rstx_alu_valid", ifc.alu_valid, 0);
    chk("rstx_alu_op",    ifc.alu_op, 0);
    chk("rstx_alu_a",     ifc.alu_a, 0);
    chk("rstx_alu_b",     ifc.alu_b, 0);
    chk("rstx_rsp0",      ifc.rsp0_valid, 0);
    chk("rstx_rsp_data",  ifc.rsp_data, 0);
    chk("rstx_req0_ready", ifc.req0_ready, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("rstx_no_rsp0", ifc.rsp0_valid, 0);
    end
    chk("rstx_data_hold", ifc.rsp_data, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
